// File: rtl/aes_inv_key_scheduler_if.sv
// Key-load and round-key read bundle between the decryptor control and the key scheduler.
interface aes_inv_key_scheduler_if;
    localparam int unsigned KW    = 128;
    localparam int unsigned IDX_W = 4;

    logic             key_load;
    logic [KW-1:0]    key_in;
    logic             key_busy;
    logic             key_ready;
    logic             rk_req;
    logic [IDX_W-1:0] rk_idx;
    logic             rk_valid;
    logic [KW-1:0]    rk_out;
    logic             rk_err;

    modport master (
        output key_load, key_in, rk_req, rk_idx,
        input  key_busy, key_ready, rk_valid, rk_out, rk_err
    );

    modport slave (
        input  key_load, key_in, rk_req, rk_idx,
        output key_busy, key_ready, rk_valid, rk_out, rk_err
    );
endinterface

// File: rtl/aes_inv_key_scheduler.sv
// Sequential AES-128 key expansion with one shared KeyGeneration round, serving round keys by index.
// Optional macro KEY_CACHE_EN: skip re-expansion when the reloaded key equals the last expanded key.
module aes_inv_key_scheduler #(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    aes_inv_key_scheduler_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(NR + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // rc=0 -> Rcon 0x01 (round key 1) ... rc=9 -> Rcon 0x36 (round key 10)
    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [KW-1:0] key_gen(input logic [KW-1:0] key, input logic [3:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = key[127:96];
        w1 = key[95:64];
        w2 = key[63:32];
        w3 = key[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {RCON[rc], 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [1:0]    state, state_nxt;
    logic [3:0]    rnd;
    logic [KW-1:0] store [0:NR];
    logic          cache_hit_c;
    logic          start_c;
    logic          rd_accept_c;

`ifdef KEY_CACHE_EN
    logic [KW-1:0] tag;
    logic          tag_valid;

    // Tag tracks the last key whose expansion ran to completion; only rst can abort one.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag       <= '0;
            tag_valid <= 1'b0;
        end else if (state == ST_EXPAND && state_nxt == ST_READY) begin
            tag       <= store[0];
            tag_valid <= 1'b1;
        end
    end

    assign cache_hit_c = tag_valid && (bus.key_in == tag);
`else
    assign cache_hit_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Load beats a same-cycle read request; a cache hit leaves the read port serving.
    always_comb begin
        state_nxt   = state;
        start_c     = 1'b0;
        rd_accept_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.key_load) begin
                    start_c   = 1'b1;
                    state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (rnd == 4'(NR - 1)) state_nxt = ST_READY;
            end
            ST_READY: begin
                if (bus.key_load && !cache_hit_c) begin
                    start_c   = 1'b1;
                    state_nxt = ST_EXPAND;
                end else if (bus.rk_req) begin
                    rd_accept_c = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd           <= 4'd0;
            store         <= '{default: '0};
            bus.key_busy  <= 1'b0;
            bus.key_ready <= 1'b0;
            bus.rk_valid  <= 1'b0;
            bus.rk_err    <= 1'b0;
            bus.rk_out    <= '0;
        end else begin
            bus.key_busy  <= (state_nxt == ST_EXPAND);
            bus.key_ready <= (state_nxt == ST_READY);
            bus.rk_valid  <= rd_accept_c;

            if (start_c) begin
                store[0] <= bus.key_in;
                rnd      <= 4'd0;
            end else if (state == ST_EXPAND) begin
                store[IDX_W'(rnd + 4'd1)] <= key_gen(store[IDX_W'(rnd)], rnd);
                if (state_nxt == ST_EXPAND) rnd <= rnd + 4'd1;
            end

            if (rd_accept_c) begin
                if (bus.rk_idx > 4'(NR)) begin
                    bus.rk_err <= 1'b1;
                    bus.rk_out <= '0;
                end else begin
                    bus.rk_err <= 1'b0;
                    bus.rk_out <= store[IDX_W'(bus.rk_idx)];
                end
            end else begin
                bus.rk_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Directed bench for aes_inv_key_scheduler against FIPS-197 round-key vectors.
module tb_aes_inv_key_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    aes_inv_key_scheduler_if bus ();

    aes_inv_key_scheduler #(.NR(10), .KW(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [127:0] rk_a [0:10];
    logic [127:0] key_a, key_z, rk1_z, rk10_z;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.key_ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Returns clocks from the load edge until key_ready is seen, and key_busy cycles seen.
    task automatic load_key(input logic [127:0] k, output int busy_n, output int ready_n);
        int n;
        n = 0;
        busy_n = 0;
        bus.key_load = 1'b1;
        bus.key_in   = k;
        do begin
            tick();
            n++;
            bus.key_load = 1'b0;
            if (bus.key_busy) busy_n++;
        end while (!bus.key_ready && n < 40);
        ready_n = bus.key_ready ? n : -1;
    endtask

    task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        bus.rk_req = 1'b1;
        bus.rk_idx = idx;
        tick();
        bus.rk_req = 1'b0;
        check({tag, "_valid"}, 128'(bus.rk_valid), 128'd1);
        check({tag, "_err"}, 128'(bus.rk_err), 128'd0);
        check(tag, bus.rk_out, exp);
    endtask

    initial begin
        int busy_n, ready_n, n;
        logic saw_valid, ready_dropped;

        key_a    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_a[0]  = key_a;
        rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        key_z    = 128'h0;
        rk1_z    = 128'h62636363626363636263636362636363;
        rk10_z   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        bus.key_load = 1'b0;
        bus.key_in   = '0;
        bus.rk_req   = 1'b0;
        bus.rk_idx   = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 128'(bus.key_busy), 128'd0);
        check("rst_ready", 128'(bus.key_ready), 128'd0);
        check("rst_valid", 128'(bus.rk_valid), 128'd0);
        check("rst_err", 128'(bus.rk_err), 128'd0);
        check("rst_out", bus.rk_out, 128'd0);

        // 1: basic expansion latency and FIPS-197 keys
        load_key(key_a, busy_n, ready_n);
        check("t1_busy_cycles", 128'(busy_n), 128'd10);
        check("t1_ready_at", 128'(ready_n), 128'd11);
        check("t1_busy_in_ready", 128'(bus.key_busy), 128'd0);
        read_rk(4'd1, rk_a[1], "t1_idx1");
        read_rk(4'd10, rk_a[10], "t1_idx10");
        tick();
        check("t1_hold_valid", 128'(bus.rk_valid), 128'd0);
        check("t1_hold_out", bus.rk_out, rk_a[10]);

        // 2: back-to-back reads in decrypt order
        for (int i = 0; i <= 10; i++) begin
            bus.rk_req = 1'b1;
            bus.rk_idx = 4'(10 - i);
            tick();
            check($sformatf("t2_valid_%0d", 10 - i), 128'(bus.rk_valid), 128'd1);
            check($sformatf("t2_rk_%0d", 10 - i), bus.rk_out, rk_a[10 - i]);
        end
        bus.rk_req = 1'b0;
        tick();
        check("t2_valid_after", 128'(bus.rk_valid), 128'd0);

        // 3: requests during EXPAND ignored; out-of-range index flagged
        bus.key_load = 1'b1;
        bus.key_in   = key_a;
        tick();
        bus.key_load = 1'b0;
        bus.rk_req   = 1'b1;
        bus.rk_idx   = 4'd2;
        saw_valid    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            saw_valid |= bus.rk_valid;
        end
        bus.rk_req = 1'b0;
        tick();
        saw_valid |= bus.rk_valid;
        check("t3_no_valid_expand", 128'(saw_valid), 128'd0);
        check("t3_ready", 128'(bus.key_ready), 128'd1);
        bus.rk_req = 1'b1;
        bus.rk_idx = 4'd11;
        tick();
        bus.rk_req = 1'b0;
        check("t3_oor_valid", 128'(bus.rk_valid), 128'd1);
        check("t3_oor_err", 128'(bus.rk_err), 128'd1);
        check("t3_oor_out", bus.rk_out, 128'd0);
        tick();
        check("t3_err_clear", 128'(bus.rk_err), 128'd0);

        // 4: reset mid-expansion, then a clean reload
        bus.key_load = 1'b1;
        bus.key_in   = key_a;
        tick();
        bus.key_load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t4_busy_pre", 128'(bus.key_busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", 128'(bus.key_busy), 128'd0);
        check("t4_ready", 128'(bus.key_ready), 128'd0);
        check("t4_valid", 128'(bus.rk_valid), 128'd0);
        check("t4_out", bus.rk_out, 128'd0);
        bus.rk_req = 1'b1;
        bus.rk_idx = 4'd0;
        tick();
        bus.rk_req = 1'b0;
        check("t4_idle_req", 128'(bus.rk_valid), 128'd0);
        load_key(key_a, busy_n, ready_n);
        check("t4_ready_at", 128'(ready_n), 128'd11);
        read_rk(4'd5, rk_a[5], "t4_idx5");

        // 5: load beats read; load during EXPAND ignored
        bus.key_load = 1'b1;
        bus.key_in   = key_z;
        bus.rk_req   = 1'b1;
        bus.rk_idx   = 4'd3;
        tick();
        bus.key_load = 1'b0;
        bus.rk_req   = 1'b0;
        check("t5_no_valid", 128'(bus.rk_valid), 128'd0);
        check("t5_ready_drop", 128'(bus.key_ready), 128'd0);
        tick();
        tick();
        bus.key_load = 1'b1;
        bus.key_in   = key_a;
        tick();
        bus.key_load = 1'b0;
        wait_ready(n);
        check("t5_ready", 128'(bus.key_ready), 128'd1);
        read_rk(4'd10, rk10_z, "t5_idx10");
        read_rk(4'd1, rk1_z, "t5_idx1");
        read_rk(4'd0, key_z, "t5_idx0");

        // 6: reload the same key, then a different key
        ready_dropped = 1'b0;
        bus.key_load = 1'b1;
        bus.key_in   = key_z;
        n = 0;
        do begin
            tick();
            n++;
            bus.key_load = 1'b0;
            if (!bus.key_ready) ready_dropped = 1'b1;
        end while (!bus.key_ready && n < 40);
`ifdef KEY_CACHE_EN
        check("t6_same_dropped", 128'(ready_dropped), 128'd0);
        check("t6_same_ready_at", 128'(n), 128'd1);
`else
        check("t6_same_dropped", 128'(ready_dropped), 128'd1);
        check("t6_same_ready_at", 128'(n), 128'd11);
`endif
        read_rk(4'd10, rk10_z, "t6_same_idx10");
        load_key(key_a, busy_n, ready_n);
        check("t6_diff_busy", 128'(busy_n), 128'd10);
        check("t6_diff_ready_at", 128'(ready_n), 128'd11);
        read_rk(4'd10, rk_a[10], "t6_diff_idx10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
